// File: rtl/unidade_controle.sv
// Multi-cycle control FSM for the unidadeProcessamento datapath (RV64 subset:
// add/sub/and, addi, ld, sd, beq/bne, lui). Control word is decoded from state + IR.
module unidade_controle #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [31:0]     inst,
  input  logic            Zero,
  output logic            PCSrc,
  output logic [2:0]      ALUFunct,
  output logic [2:0]      ALUSrcB,
  output logic            ALUSrcA,
  output logic            LoadRegA,
  output logic            LoadRegB,
  output logic            LoadALUOut,
  output logic            LoadIR,
  output logic            LoadMDR,
  output logic            PCWrite,
  output logic            IMemLoad,
  output logic            DMemLoad,
  output logic            RegWrite,
  output logic            MemToReg,
  output logic            Illegal,
  output logic [ST_W-1:0] state_dbg
);

  typedef enum logic [ST_W-1:0] {
    S_RESET      = ST_W'(0),
    S_FETCH      = ST_W'(1),
    S_FETCH_WAIT = ST_W'(2),
    S_DECODE     = ST_W'(3),
    S_EXEC_R     = ST_W'(4),
    S_EXEC_I     = ST_W'(5),
    S_EXEC_U     = ST_W'(6),
    S_WB_ALU     = ST_W'(7),
    S_ADDR_L     = ST_W'(8),
    S_MEM_RD     = ST_W'(9),
    S_MEM_WAIT   = ST_W'(10),
    S_WB_MEM     = ST_W'(11),
    S_ADDR_S     = ST_W'(12),
    S_MEM_WR     = ST_W'(13),
    S_BRANCH     = ST_W'(14),
    S_ILLEGAL    = ST_W'(15)
  } state_t;

  localparam logic [2:0] F_PASS_B = 3'b000;
  localparam logic [2:0] F_ADD    = 3'b001;
  localparam logic [2:0] F_SUB    = 3'b010;
  localparam logic [2:0] F_AND    = 3'b011;

  localparam logic [2:0] B_REGB  = 3'b000;
  localparam logic [2:0] B_FOUR  = 3'b001;
  localparam logic [2:0] B_IMMI  = 3'b010;
  localparam logic [2:0] B_IMMS  = 3'b011;
  localparam logic [2:0] B_IMMSB = 3'b100;
  localparam logic [2:0] B_IMMU  = 3'b101;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       r_ok;
  logic [2:0] r_funct;
  logic       unused_bits;

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign funct7      = inst[31:25];
  assign unused_bits = ^{inst[24:15], inst[11:7]};
  assign state_dbg   = state;

  assign r_ok = (funct3 == 3'd0 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
                (funct3 == 3'd7 && funct7 == 7'h00);
  assign r_funct = (funct3 == 3'd7) ? F_AND : ((funct7 == 7'h20) ? F_SUB : F_ADD);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET:      state <= S_FETCH;
        S_FETCH:      state <= S_FETCH_WAIT;
        S_FETCH_WAIT: state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_R:      state <= r_ok ? S_EXEC_R : S_ILLEGAL;
            OP_I:      state <= (funct3 == 3'd0) ? S_EXEC_I : S_ILLEGAL;
            OP_LOAD:   state <= (funct3 == 3'd3) ? S_ADDR_L : S_ILLEGAL;
            OP_STORE:  state <= (funct3 == 3'd3) ? S_ADDR_S : S_ILLEGAL;
            OP_BRANCH: state <= (funct3 == 3'd0 || funct3 == 3'd1) ? S_BRANCH : S_ILLEGAL;
            OP_LUI:    state <= S_EXEC_U;
            default:   state <= S_ILLEGAL;
          endcase
        end
        S_EXEC_R, S_EXEC_I, S_EXEC_U: state <= S_WB_ALU;
        S_ADDR_L:   state <= S_MEM_RD;
        S_MEM_RD:   state <= S_MEM_WAIT;
        S_MEM_WAIT: state <= S_WB_MEM;
        S_ADDR_S:   state <= S_MEM_WR;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // The RESET state decodes to an all-zero word, so outputs drop with the async reset.
  always_comb begin
    PCSrc      = 1'b0;
    ALUFunct   = F_PASS_B;
    ALUSrcB    = B_REGB;
    ALUSrcA    = 1'b0;
    LoadRegA   = 1'b0;
    LoadRegB   = 1'b0;
    LoadALUOut = 1'b0;
    LoadIR     = 1'b0;
    LoadMDR    = 1'b0;
    PCWrite    = 1'b0;
    IMemLoad   = 1'b0;
    DMemLoad   = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    Illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB  = B_FOUR;
        ALUFunct = F_ADD;
        PCWrite  = 1'b1;
      end
      S_FETCH_WAIT: LoadIR = 1'b1;
      S_DECODE: begin
        LoadRegA   = 1'b1;
        LoadRegB   = 1'b1;
        ALUSrcB    = B_IMMSB;
        ALUFunct   = F_ADD;
        LoadALUOut = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUFunct   = r_funct;
        LoadALUOut = 1'b1;
      end
      S_EXEC_I, S_ADDR_L: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = B_IMMI;
        ALUFunct   = F_ADD;
        LoadALUOut = 1'b1;
      end
      S_EXEC_U: begin
        ALUSrcB    = B_IMMU;
        LoadALUOut = 1'b1;
      end
      S_WB_ALU:   RegWrite = 1'b1;
      S_MEM_WAIT: LoadMDR  = 1'b1;
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_ADDR_S: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = B_IMMS;
        ALUFunct   = F_ADD;
        LoadALUOut = 1'b1;
      end
      S_MEM_WR: DMemLoad = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUFunct = F_SUB;
        PCSrc    = 1'b1;
        PCWrite  = funct3[0] ? ~Zero : Zero;
      end
      S_ILLEGAL: Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: walks each instruction class state by state
// and compares state code plus full control word against hand-written expectations.
module tb_unidade_controle;

  logic        clk;
  logic        Reset;
  logic [31:0] inst;
  logic        Zero;
  logic        PCSrc, ALUSrcA, LoadRegA, LoadRegB, LoadALUOut, LoadIR, LoadMDR;
  logic        PCWrite, IMemLoad, DMemLoad, RegWrite, MemToReg, Illegal;
  logic [2:0]  ALUFunct, ALUSrcB;
  logic [3:0]  state_dbg;
  logic [18:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  unidade_controle #(.ST_W(4)) dut (
    .clk(clk), .Reset(Reset), .inst(inst), .Zero(Zero),
    .PCSrc(PCSrc), .ALUFunct(ALUFunct), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA),
    .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .LoadALUOut(LoadALUOut),
    .LoadIR(LoadIR), .LoadMDR(LoadMDR), .PCWrite(PCWrite), .IMemLoad(IMemLoad),
    .DMemLoad(DMemLoad), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .Illegal(Illegal), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl = {PCSrc, ALUFunct, ALUSrcB, ALUSrcA, LoadRegA, LoadRegB, LoadALUOut,
                LoadIR, LoadMDR, PCWrite, IMemLoad, DMemLoad, RegWrite, MemToReg, Illegal};

  function automatic logic [18:0] cw(input logic pcsrc, input logic [2:0] fn,
                                     input logic [2:0] srcb, input logic srca,
                                     input logic lra, input logic lrb, input logic lalu,
                                     input logic lir, input logic lmdr, input logic pcw,
                                     input logic dmem, input logic regw, input logic m2r,
                                     input logic ill);
    return {pcsrc, fn, srcb, srca, lra, lrb, lalu, lir, lmdr, pcw, 1'b0, dmem, regw, m2r, ill};
  endfunction

  localparam logic [3:0] S_RESET = 4'd0,  S_FETCH = 4'd1,  S_FW = 4'd2,      S_DEC = 4'd3;
  localparam logic [3:0] S_EXR   = 4'd4,  S_EXI   = 4'd5,  S_EXU = 4'd6,     S_WBA = 4'd7;
  localparam logic [3:0] S_ADL   = 4'd8,  S_MRD   = 4'd9,  S_MWAIT = 4'd10,  S_WBM = 4'd11;
  localparam logic [3:0] S_ADS   = 4'd12, S_MWR   = 4'd13, S_BR = 4'd14,     S_ILL = 4'd15;

  //                               pcs fn     srcb   a  ra rb alu ir mdr pcw dm rw m2r ill
  localparam logic [18:0] W_ZERO  = 19'd0;
  localparam logic [18:0] W_FETCH = cw(0, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  localparam logic [18:0] W_FW    = cw(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] W_DEC   = cw(0, 3'd1, 3'd4, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] W_ADD   = cw(0, 3'd1, 3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] W_SUB   = cw(0, 3'd2, 3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] W_AND   = cw(0, 3'd3, 3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] W_IMMI  = cw(0, 3'd1, 3'd2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] W_LUI   = cw(0, 3'd0, 3'd5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] W_WBA   = cw(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  localparam logic [18:0] W_MWAIT = cw(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  localparam logic [18:0] W_WBM   = cw(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
  localparam logic [18:0] W_ADS   = cw(0, 3'd1, 3'd3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] W_MWR   = cw(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  localparam logic [18:0] W_BR1   = cw(1, 3'd2, 3'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  localparam logic [18:0] W_BR0   = cw(1, 3'd2, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] W_ILL   = cw(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the middle of the next cycle and compare state and control word.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [18:0] w);
    @(negedge clk);
    check_val({tag, ".state"}, {28'd0, state_dbg}, {28'd0, st});
    check_val({tag, ".ctl"}, {13'd0, ctl}, {13'd0, w});
  endtask

  task automatic start(input string tag, input logic [31:0] instr, input logic z);
    inst = instr;
    Zero = z;
    $display("txn %-10s inst=0x%08h zero=%0b", tag, instr, z);
    cyc({tag, ".fetch"}, S_FETCH, W_FETCH);
    cyc({tag, ".fwait"}, S_FW, W_FW);
    cyc({tag, ".decode"}, S_DEC, W_DEC);
  endtask

  initial begin
    Reset = 1'b1;
    inst  = 32'd0;
    Zero  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("reset.state", {28'd0, state_dbg}, {28'd0, S_RESET});
    check_val("reset.ctl", {13'd0, ctl}, {13'd0, W_ZERO});
    Reset = 1'b0;

    start("add", 32'h002081B3, 1'b0);
    cyc("add.exec", S_EXR, W_ADD);
    cyc("add.wb", S_WBA, W_WBA);

    start("sub", 32'h402081B3, 1'b0);
    cyc("sub.exec", S_EXR, W_SUB);
    cyc("sub.wb", S_WBA, W_WBA);

    start("and", 32'h0020F1B3, 1'b0);
    cyc("and.exec", S_EXR, W_AND);
    cyc("and.wb", S_WBA, W_WBA);

    start("addi", 32'h00508093, 1'b0);
    cyc("addi.exec", S_EXI, W_IMMI);
    cyc("addi.wb", S_WBA, W_WBA);

    start("lui", 32'h123450B7, 1'b0);
    cyc("lui.exec", S_EXU, W_LUI);
    cyc("lui.wb", S_WBA, W_WBA);

    start("ld", 32'h0080B283, 1'b0);
    cyc("ld.addr", S_ADL, W_IMMI);
    cyc("ld.memrd", S_MRD, W_ZERO);
    cyc("ld.memwait", S_MWAIT, W_MWAIT);
    cyc("ld.wb", S_WBM, W_WBM);

    start("sd", 32'h0050B823, 1'b0);
    cyc("sd.addr", S_ADS, W_ADS);
    cyc("sd.memwr", S_MWR, W_MWR);

    start("beq_z1", 32'h00208463, 1'b1);
    cyc("beq_z1.br", S_BR, W_BR1);
    start("beq_z0", 32'h00208463, 1'b0);
    cyc("beq_z0.br", S_BR, W_BR0);
    start("bne_z1", 32'h00209463, 1'b1);
    cyc("bne_z1.br", S_BR, W_BR0);
    start("bne_z0", 32'h00209463, 1'b0);
    cyc("bne_z0.br", S_BR, W_BR1);

    start("ill_ones", 32'hFFFFFFFF, 1'b0);
    cyc("ill_ones.ill", S_ILL, W_ILL);
    start("ill_sll", 32'h002091B3, 1'b0);
    cyc("ill_sll.ill", S_ILL, W_ILL);
    start("ill_xori", 32'h0050C093, 1'b0);
    cyc("ill_xori.ill", S_ILL, W_ILL);

    // Reset asserted in the middle of MEM_WR, away from any clock edge.
    start("sd_rst", 32'h0050B823, 1'b0);
    cyc("sd_rst.addr", S_ADS, W_ADS);
    cyc("sd_rst.memwr", S_MWR, W_MWR);
    #1 Reset = 1'b1;
    #1;
    check_val("rst_async.state", {28'd0, state_dbg}, {28'd0, S_RESET});
    check_val("rst_async.dmem", {31'd0, DMemLoad}, 32'd0);
    check_val("rst_async.ctl", {13'd0, ctl}, {13'd0, W_ZERO});
    cyc("rst_hold", S_RESET, W_ZERO);
    Reset = 1'b0;
    cyc("rst_release.fetch", S_FETCH, W_FETCH);
    cyc("rst_release.fwait", S_FW, W_FW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
